// File: rtl/led_bus_arbiter_pkg.sv
// led_bus_arbiter_pkg: shared types, defaults and helpers
// for the LED bus arbiter and its round-robin picker.
package led_bus_arbiter_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_HOLD  = 4;

  // Index width for v values; never below 1 bit so
  // that degenerate sizes still yield a legal vector.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/led_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports: req (requests), ptr (top-priority index),
// any (some request set), winner (first set bit at/after ptr).
module rr_picker
  import led_bus_arbiter_pkg::*;
#(
  parameter int N  = DEF_N_REQ,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] winner
);

  logic [IW-1:0] idx;

  // Scan from the far end back toward ptr so the
  // last hit written is the nearest one to ptr.
  always_comb begin
    any    = |req;
    winner = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/led_bus_arbiter.sv
// led_bus_arbiter: round-robin owner of a registered
// output bus. Ports: clk, rst (sync, active-high), req,
// data (packed lanes), gnt, out, out_valid, done.
module led_bus_arbiter
  import led_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int HOLD  = DEF_HOLD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       out,
  output logic                   out_valid,
  output logic [N_REQ-1:0]       done
);

  localparam int IW = clog2(N_REQ);
  localparam int CW = clog2(HOLD);

  localparam logic [CW-1:0] CNT_INIT = CW'(HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] LAST     = IW'(N_REQ - 1);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] w;
  logic [CW-1:0] cnt;

  logic             pick_any;
  logic [IW-1:0]    pick_w;
  logic [N_REQ-1:0] pick_oh;

  logic [WIDTH-1:0] lane [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane[i] = data[i*WIDTH +: WIDTH];
  end

  rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .winner (pick_w)
  );

  always_comb begin
    pick_oh         = '0;
    pick_oh[pick_w] = 1'b1;
  end

  // done is registered one edge early: it rises on the
  // edge that makes cnt reach zero (or on the grant edge
  // itself when a slot is only one cycle long).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      w         <= '0;
      cnt       <= '0;
      out       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      done      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            w         <= pick_w;
            out       <= lane[pick_w];
            cnt       <= CNT_INIT;
            gnt       <= pick_oh;
            out_valid <= 1'b1;
            done      <= (CNT_INIT == '0) ? pick_oh : '0;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
            done <= (cnt == CNT_ONE) ? gnt : '0;
          end else begin
            ptr       <= (w == LAST) ? '0 : w + 1'b1;
            out       <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            done      <= '0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/led_bus_arbiter.md
# led_bus_arbiter

Round-robin arbiter and sequencer that shares one registered 8-bit output bus, such as the board LED bank, between several requesters. Each requester presents a request and an 8-bit value. The arbiter grants one requester at a time, holds that requester's value on the bus for a fixed number of cycles, then releases the bus and rotates priority. It sits between the switch/processing sources and the 8-bit pass-through output path.

## Interface
Parameters:
- N_REQ, 4: number of requesters (2..8).
- WIDTH, 8: data width of each requester and of the bus.
- HOLD, 4: cycles each grant drives the bus (≥1).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  N_REQ  request lines; req[i] is level-sensitive.
- data  in  N_REQ*WIDTH  requester i's value is data[i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant; all zero when idle.
- out  out  WIDTH  registered bus value.
- out_valid  out  1  high while a grant is driving out.
- done  out  N_REQ  one-cycle pulse on bit w in the last cycle of w's slot.

One clock; reset is synchronous and active-high.

## Operation
- States are IDLE and HOLD.
- Registers: state, ptr (0..N_REQ-1, highest-priority index), cnt (down-counter, clog2(HOLD) bits, minimum 1), w (winner index), out.
- IDLE:
  - gnt=0, out=0, out_valid=0, done=0.
  - If req≠0, the winner is the first set bit scanning ptr, ptr+1, … modulo N_REQ.
  - On that edge: latch data[w] into out, set cnt=HOLD-1, go to HOLD.
  - If req=0, stay in IDLE.
- HOLD:
  - gnt[w]=1, out_valid=1, out holds the latched value.
  - Changes on data or req are ignored; dropping req does not abort the slot.
  - While cnt≠0, decrement cnt.
  - When cnt=0: done[w]=1 this cycle; on the edge set ptr=(w+1) mod N_REQ and go to IDLE.
- No back-to-back grants. Every slot is followed by exactly one IDLE cycle, which is the arbitration cycle.
- A requester that keeps req high is re-served only after every other active requester has been served once (fairness).
- Reset (any state, including mid-HOLD): on the next edge state=IDLE, ptr=0, cnt=0, out=0, and gnt, out_valid, done all 0.
- Reset takes precedence over arbitration on the same edge.

## Timing
- Reset values: gnt=0, out=0, out_valid=0, done=0, ptr=0.
- Grant latency is 1 cycle. With req sampled high in IDLE cycle c, the bus is driven in cycles c+1 … c+HOLD.
- gnt, out and out_valid rise together in cycle c+1.
- done[w] is high only in cycle c+HOLD.
- Cycle c+HOLD+1 is IDLE (outputs 0). A new grant is visible at c+HOLD+2 at the earliest.
- Peak throughput is one grant per HOLD+1 cycles.
- HOLD=1 boundary: the slot lasts one cycle and done coincides with the first out_valid cycle.
- ptr wrap-around: a winner at N_REQ-1 sets ptr to 0.
- All outputs are registered or decoded from registers. There is no combinational path from req or data to any output.

## Structure
- Shared package/header holds:
  - the state encoding (IDLE=1'b0, HOLD=1'b1);
  - default parameter values;
  - the index-width function clog2.
- One sub-module, rr_picker: a combinational round-robin priority selector.
  - Inputs: req, ptr.
  - Outputs: any and winner index.
  - Reusable by other shared-resource controllers.

## Test plan
With N_REQ=4, WIDTH=8, HOLD=4:
- Reset then single request: rst high for 2 cycles; req=4'b0100, data[2]=8'hA5 → one cycle later gnt=4'b0100, out=8'hA5, out_valid high for 4 cycles, done[2] in the 4th, then one IDLE cycle with out=0; ptr becomes 3.
- Round-robin rotation: req=4'b1111 held with distinct values 8'h11/22/33/44 → grants in order 0,1,2,3,0, spaced 5 cycles apart, out matching each value.
- Data stability and request drop: during slot 1, change data[1] to 8'hFF and drop req[1] → out stays at the latched 8'h22 for all 4 cycles and done[1] still pulses.
- Wrap priority: ptr=3 after serving 2; req=4'b1001 → requester 3 wins, then 0.
- Reset mid-HOLD: assert rst in the 2nd hold cycle → next cycle gnt=0, out=0, out_valid=0, no done pulse; with req=4'b0010 the first grant after reset goes to 1 with ptr reset to 0.
- HOLD=1 build: req=4'b0001 → out_valid and done[0] both high for exactly one cycle, with a grant every 2 cycles.
